circular_bounds_table: RTL and testbench

Parametrised successor of the first/last address-range circular buffer used by the memory-safety checker. Stores up to DEPTH valid [first, last] regions in a wrap-around table with per-entry valid bits. Supports region free by base address, synchronous flush, occupancy and eviction reporting, and a registered lookup that flags in-range, base-match and access-overflow (access crossing a region's last byte). Sits between the allocator-tracking logic in the load/store path and the overflow-exception generation.

---
 rtl/circular_bounds_table_if.sv | 47 ++++
 rtl/circular_bounds_table.sv | 174 +++++++++++++++++
 tb/tb_circular_bounds_table.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/circular_bounds_table_if.sv
// Request/response bundle for circular_bounds_table: alloc, free and lookup
// channels plus status. The master side drives requests and the slave side answers.
interface circular_bounds_table_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              alloc_valid_i;
  logic [ADDR_W-1:0] alloc_first_i;
  logic [ADDR_W-1:0] alloc_last_i;
  logic              alloc_err_o;
  logic              evict_o;
  logic              free_valid_i;
  logic [ADDR_W-1:0] free_first_i;
  logic              free_hit_o;
  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic [3:0]        lookup_len_i;
  logic              rsp_valid_o;
  logic              rsp_in_range_o;
  logic              rsp_is_first_o;
  logic              rsp_overflow_o;
  logic [ADDR_W-1:0] rsp_first_o;
  logic [ADDR_W-1:0] rsp_last_o;
  logic [ADDR_W-1:0] last_first_o;
  logic [ADDR_W-1:0] last_last_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_first_i, alloc_last_i,
           free_valid_i, free_first_i, lookup_valid_i, lookup_addr_i, lookup_len_i,
    input  alloc_err_o, evict_o, free_hit_o, rsp_valid_o, rsp_in_range_o,
           rsp_is_first_o, rsp_overflow_o, rsp_first_o, rsp_last_o,
           last_first_o, last_last_o, count_o, full_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_first_i, alloc_last_i,
           free_valid_i, free_first_i, lookup_valid_i, lookup_addr_i, lookup_len_i,
    output alloc_err_o, evict_o, free_hit_o, rsp_valid_o, rsp_in_range_o,
           rsp_is_first_o, rsp_overflow_o, rsp_first_o, rsp_last_o,
           last_first_o, last_last_o, count_o, full_o
  );
endinterface

// File: rtl/circular_bounds_table.sv
// Wrap-around table of [first, last] address regions with free-by-base,
// flush, occupancy reporting and a registered bounds/overflow lookup.
module circular_bounds_table #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  circular_bounds_table_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int EXT_W = ADDR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] first_q [DEPTH];
  logic [ADDR_W-1:0] first_d [DEPTH];
  logic [ADDR_W-1:0] last_q  [DEPTH];
  logic [ADDR_W-1:0] last_d  [DEPTH];
  logic [IDX_W-1:0]  cursor_q, cursor_d;
  logic [ADDR_W-1:0] last_first_q, last_first_d;
  logic [ADDR_W-1:0] last_last_q, last_last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              alloc_err_q, alloc_err_d;
  logic              evict_q, evict_d;
  logic              free_hit_q, free_hit_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_in_range_q, rsp_in_range_d;
  logic              rsp_is_first_q, rsp_is_first_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic [ADDR_W-1:0] rsp_first_q, rsp_first_d;
  logic [ADDR_W-1:0] rsp_last_q, rsp_last_d;

  logic [DEPTH-1:0]  free_match;
  logic              alloc_ok;
  logic              look_hit;
  logic              look_is_first;
  logic [ADDR_W-1:0] look_first;
  logic [ADDR_W-1:0] look_last;
  logic [3:0]        len_eff;
  logic [EXT_W-1:0]  access_end;

  // Free is applied before the alloc so a slot freed this cycle is not counted as evicted.
  always_comb begin
    valid_d      = valid_q;
    first_d      = first_q;
    last_d       = last_q;
    cursor_d     = cursor_q;
    last_first_d = last_first_q;
    last_last_d  = last_last_q;
    alloc_err_d  = 1'b0;
    evict_d      = 1'b0;
    free_hit_d   = 1'b0;
    free_match   = '0;
    count_d      = '0;
    alloc_ok     = bus.alloc_valid_i && (bus.alloc_first_i <= bus.alloc_last_i);

    for (int i = 0; i < DEPTH; i++) begin
      free_match[i] = bus.free_valid_i && valid_q[i] && (first_q[i] == bus.free_first_i);
    end

    if (bus.flush_i) begin
      valid_d      = '0;
      cursor_d     = '0;
      last_first_d = '0;
      last_last_d  = '0;
    end else begin
      valid_d     = valid_q & ~free_match;
      free_hit_d  = |free_match;
      alloc_err_d = bus.alloc_valid_i && !alloc_ok;
      if (alloc_ok) begin
        evict_d           = valid_d[cursor_q];
        valid_d[cursor_q] = 1'b1;
        first_d[cursor_q] = bus.alloc_first_i;
        last_d[cursor_q]  = bus.alloc_last_i;
        cursor_d          = cursor_q + 1'b1;
        last_first_d      = bus.alloc_first_i;
        last_last_d       = bus.alloc_last_i;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  // Lookup sees only pre-cycle state; scanning downwards leaves the lowest hit index.
  always_comb begin
    len_eff       = (bus.lookup_len_i == 4'd0) ? 4'd1 : bus.lookup_len_i;
    access_end    = {1'b0, bus.lookup_addr_i} + EXT_W'(len_eff) - EXT_W'(1);
    look_hit      = 1'b0;
    look_is_first = 1'b0;
    look_first    = '0;
    look_last     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (first_q[i] <= bus.lookup_addr_i) && (bus.lookup_addr_i <= last_q[i])) begin
        look_hit   = 1'b1;
        look_first = first_q[i];
        look_last  = last_q[i];
      end
      if (valid_q[i] && (first_q[i] == bus.lookup_addr_i)) begin
        look_is_first = 1'b1;
      end
    end

    rsp_valid_d    = bus.lookup_valid_i;
    rsp_in_range_d = 1'b0;
    rsp_is_first_d = 1'b0;
    rsp_overflow_d = 1'b0;
    rsp_first_d    = '0;
    rsp_last_d     = '0;
    if (bus.lookup_valid_i) begin
      rsp_in_range_d = look_hit;
      rsp_is_first_d = look_is_first;
      rsp_overflow_d = look_hit && (access_end > {1'b0, look_last});
      rsp_first_d    = look_first;
      rsp_last_d     = look_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
      cursor_q       <= '0;
      last_first_q   <= '0;
      last_last_q    <= '0;
      count_q        <= '0;
      alloc_err_q    <= 1'b0;
      evict_q        <= 1'b0;
      free_hit_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_in_range_q <= 1'b0;
      rsp_is_first_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_first_q    <= '0;
      rsp_last_q     <= '0;
    end else begin
      valid_q        <= valid_d;
      first_q        <= first_d;
      last_q         <= last_d;
      cursor_q       <= cursor_d;
      last_first_q   <= last_first_d;
      last_last_q    <= last_last_d;
      count_q        <= count_d;
      alloc_err_q    <= alloc_err_d;
      evict_q        <= evict_d;
      free_hit_q     <= free_hit_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_in_range_q <= rsp_in_range_d;
      rsp_is_first_q <= rsp_is_first_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_first_q    <= rsp_first_d;
      rsp_last_q     <= rsp_last_d;
    end
  end

  assign bus.alloc_err_o    = alloc_err_q;
  assign bus.evict_o        = evict_q;
  assign bus.free_hit_o     = free_hit_q;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_in_range_o = rsp_in_range_q;
  assign bus.rsp_is_first_o = rsp_is_first_q;
  assign bus.rsp_overflow_o = rsp_overflow_q;
  assign bus.rsp_first_o    = rsp_first_q;
  assign bus.rsp_last_o     = rsp_last_q;
  assign bus.last_first_o   = last_first_q;
  assign bus.last_last_o    = last_last_q;
  assign bus.count_o        = count_q;
  assign bus.full_o         = (count_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_circular_bounds_table.sv
// Bench for circular_bounds_table at DEPTH=4: directed vector table, reset
// corner sequences, then random traffic against a behavioural region model.
module tb_circular_bounds_table;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic        flush;
    logic        alloc_v;
    logic [31:0] af;
    logic [31:0] al;
    logic        free_v;
    logic [31:0] ff;
    logic        look_v;
    logic [31:0] la;
    logic [3:0]  len;
    logic        e_rsp_v;
    logic        e_in;
    logic        e_isf;
    logic        e_ovf;
    logic [31:0] e_rf;
    logic [31:0] e_rl;
    int          e_cnt;
    logic        e_full;
    logic        e_evict;
    logic        e_err;
    logic        e_fhit;
    logic [31:0] e_lastf;
    logic [31:0] e_lastl;
    logic        chk_lastl;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   check_count = 0;
  int   pass_count = 0;

  circular_bounds_table_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  circular_bounds_table #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a plain list of regions plus an insertion pointer.
  logic        m_valid [DEPTH];
  logic [31:0] m_first [DEPTH];
  logic [31:0] m_last  [DEPTH];
  int          m_cursor;
  logic [31:0] m_lastf;
  logic [31:0] m_lastl;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_first[i] = '0;
      m_last[i]  = '0;
    end
    m_cursor = 0;
    m_lastf  = '0;
    m_lastl  = '0;
  endtask

  task automatic modelStep(inout vec_t v);
    longint unsigned end_addr;
    int  idx;
    int  cnt;
    bit  ok;
    idx = -1;
    v.e_isf = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && idx < 0 && v.la >= m_first[i] && v.la <= m_last[i]) idx = i;
      if (m_valid[i] && m_first[i] == v.la) v.e_isf = 1'b1;
    end
    end_addr  = longint'(v.la) + ((v.len == 0) ? 1 : longint'(v.len)) - 1;
    v.e_rsp_v = v.look_v;
    v.e_in    = (idx >= 0);
    v.e_rf    = (idx >= 0) ? m_first[idx] : 32'h0;
    v.e_rl    = (idx >= 0) ? m_last[idx] : 32'h0;
    v.e_ovf   = (idx >= 0) && (end_addr > longint'(m_last[idx]));
    v.e_fhit  = 1'b0;
    v.e_evict = 1'b0;
    v.e_err   = 1'b0;
    if (v.flush) begin
      modelReset();
    end else begin
      if (v.free_v) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_valid[i] && m_first[i] == v.ff) begin
            m_valid[i] = 1'b0;
            v.e_fhit   = 1'b1;
          end
        end
      end
      ok = v.alloc_v && (v.af <= v.al);
      v.e_err = v.alloc_v && !ok;
      if (ok) begin
        v.e_evict          = m_valid[m_cursor];
        m_valid[m_cursor]  = 1'b1;
        m_first[m_cursor]  = v.af;
        m_last[m_cursor]   = v.al;
        m_cursor           = (m_cursor + 1) % DEPTH;
        m_lastf            = v.af;
        m_lastl            = v.al;
      end
    end
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += int'(m_valid[i]);
    v.e_cnt     = cnt;
    v.e_full    = (cnt == DEPTH);
    v.e_lastf   = m_lastf;
    v.e_lastl   = m_lastl;
    v.chk_lastl = 1'b1;
  endtask

  task automatic driveIdle();
    bus.flush_i        = 1'b0;
    bus.alloc_valid_i  = 1'b0;
    bus.alloc_first_i  = '0;
    bus.alloc_last_i   = '0;
    bus.free_valid_i   = 1'b0;
    bus.free_first_i   = '0;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_addr_i  = '0;
    bus.lookup_len_i   = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.flush_i        = v.flush;
    bus.alloc_valid_i  = v.alloc_v;
    bus.alloc_first_i  = v.af;
    bus.alloc_last_i   = v.al;
    bus.free_valid_i   = v.free_v;
    bus.free_first_i   = v.ff;
    bus.lookup_valid_i = v.look_v;
    bus.lookup_addr_i  = v.la;
    bus.lookup_len_i   = v.len;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'(v.e_rsp_v));
    if (v.e_rsp_v) begin
      checkField({tag, " in_range"}, 32'(bus.rsp_in_range_o), 32'(v.e_in));
      checkField({tag, " is_first"}, 32'(bus.rsp_is_first_o), 32'(v.e_isf));
      checkField({tag, " overflow"}, 32'(bus.rsp_overflow_o), 32'(v.e_ovf));
      checkField({tag, " rsp_first"}, bus.rsp_first_o, v.e_rf);
      checkField({tag, " rsp_last"}, bus.rsp_last_o, v.e_rl);
    end
    checkField({tag, " count"}, 32'(bus.count_o), 32'(v.e_cnt));
    checkField({tag, " full"}, 32'(bus.full_o), 32'(v.e_full));
    checkField({tag, " evict"}, 32'(bus.evict_o), 32'(v.e_evict));
    checkField({tag, " alloc_err"}, 32'(bus.alloc_err_o), 32'(v.e_err));
    checkField({tag, " free_hit"}, 32'(bus.free_hit_o), 32'(v.e_fhit));
    checkField({tag, " last_first"}, bus.last_first_o, v.e_lastf);
    if (v.chk_lastl) checkField({tag, " last_last"}, bus.last_last_o, v.e_lastl);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    driveIdle();
    repeat (2) @(posedge clk_i);
    #1;
    checkField("reset count", 32'(bus.count_o), 32'h0);
    checkField("reset rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    checkField("reset last_first", bus.last_first_o, 32'h0);
    rst_ni = 1'b1;
    modelReset();
  endtask

  vec_t vecs [26];
  vec_t rv;

  initial begin
    // Fields: flush, alloc_v, af, al, free_v, ff, look_v, la, len,
    //   rsp_v, in, isf, ovf, rf, rl, cnt, full, evict, err, fhit, lastf, lastl, chk_lastl
    vecs[0]  = '{0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,                  0,0,0,0,0,'h0,0,0};
    vecs[1]  = '{0,1,'h1000,'h10FF,0,0,0,0,0,       0,0,0,0,0,0,                  1,0,0,0,0,'h1000,'h10FF,1};
    vecs[2]  = '{0,0,0,0,0,0,1,'h1080,4,            1,1,0,0,'h1000,'h10FF,        1,0,0,0,0,'h1000,0,0};
    vecs[3]  = '{0,0,0,0,0,0,1,'h10FE,4,            1,1,0,1,'h1000,'h10FF,        1,0,0,0,0,'h1000,0,0};
    vecs[4]  = '{0,0,0,0,0,0,1,'h1000,0,            1,1,1,0,'h1000,'h10FF,        1,0,0,0,0,'h1000,0,0};
    vecs[5]  = '{0,0,0,0,0,0,1,'h2000,1,            1,0,0,0,0,0,                  1,0,0,0,0,'h1000,0,0};
    vecs[6]  = '{1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,                  0,0,0,0,0,'h0,'h0,1};
    vecs[7]  = '{0,1,'h000,'h00F,0,0,0,0,0,         0,0,0,0,0,0,                  1,0,0,0,0,'h000,'h00F,1};
    vecs[8]  = '{0,1,'h100,'h10F,0,0,0,0,0,         0,0,0,0,0,0,                  2,0,0,0,0,'h100,'h10F,1};
    vecs[9]  = '{0,1,'h200,'h20F,0,0,0,0,0,         0,0,0,0,0,0,                  3,0,0,0,0,'h200,'h20F,1};
    vecs[10] = '{0,1,'h300,'h30F,0,0,0,0,0,         0,0,0,0,0,0,                  4,1,0,0,0,'h300,'h30F,1};
    vecs[11] = '{0,1,'h400,'h40F,0,0,0,0,0,         0,0,0,0,0,0,                  4,1,1,0,0,'h400,'h40F,1};
    vecs[12] = '{0,0,0,0,0,0,1,'h000,1,             1,0,0,0,0,0,                  4,1,0,0,0,'h400,0,0};
    vecs[13] = '{0,0,0,0,0,0,1,'h400,1,             1,1,1,0,'h400,'h40F,          4,1,0,0,0,'h400,0,0};
    vecs[14] = '{0,1,'h100,'h17F,0,0,0,0,0,         0,0,0,0,0,0,                  4,1,1,0,0,'h100,'h17F,1};
    vecs[15] = '{0,1,'h100,'h13F,0,0,0,0,0,         0,0,0,0,0,0,                  4,1,1,0,0,'h100,'h13F,1};
    vecs[16] = '{0,0,0,0,0,0,1,'h100,1,             1,1,1,0,'h100,'h17F,          4,1,0,0,0,'h100,0,0};
    vecs[17] = '{0,0,0,0,1,'h100,0,0,0,             0,0,0,0,0,0,                  2,0,0,0,1,'h100,0,0};
    vecs[18] = '{0,0,0,0,1,'h900,0,0,0,             0,0,0,0,0,0,                  2,0,0,0,0,'h100,0,0};
    vecs[19] = '{0,1,'h20,'h10,0,0,0,0,0,           0,0,0,0,0,0,                  2,0,0,1,0,'h100,'h13F,1};
    vecs[20] = '{0,1,'h3000,'h30FF,1,'h300,1,'h3010,1, 1,0,0,0,0,0,               2,0,0,0,1,'h3000,'h30FF,1};
    vecs[21] = '{0,0,0,0,0,0,1,'h3010,1,            1,1,0,0,'h3000,'h30FF,        2,0,0,0,0,'h3000,0,0};
    vecs[22] = '{0,1,'hFFFFFF00,'hFFFFFFFF,0,0,0,0,0, 0,0,0,0,0,0,                2,0,1,0,0,'hFFFFFF00,'hFFFFFFFF,1};
    vecs[23] = '{0,0,0,0,0,0,1,'hFFFFFFFE,4,        1,1,0,1,'hFFFFFF00,'hFFFFFFFF, 2,0,0,0,0,'hFFFFFF00,0,0};
    vecs[24] = '{1,1,'h5000,'h50FF,0,0,0,0,0,       0,0,0,0,0,0,                  0,0,0,0,0,'h0,'h0,1};
    vecs[25] = '{0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,                  0,0,0,0,0,'h0,'h0,1};

    driveIdle();
    #1;
    checkField("async reset rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    doReset();

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset drops a response that was already registered.
    rv = '{default: 0};
    rv.alloc_v = 1'b1; rv.af = 32'h10; rv.al = 32'h1F;
    applyStimulus(rv);
    rv = '{default: 0};
    rv.look_v = 1'b1; rv.la = 32'h10; rv.len = 4'd1;
    applyStimulus(rv);
    checkField("pre-reset rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    checkField("pre-reset in_range", 32'(bus.rsp_in_range_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkField("mid reset rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    checkField("mid reset in_range", 32'(bus.rsp_in_range_o), 32'h0);
    checkField("mid reset count", 32'(bus.count_o), 32'h0);
    checkField("mid reset last_first", bus.last_first_o, 32'h0);
    doReset();

    for (int n = 0; n < 500; n++) begin
      rv = '{default: 0};
      if ($urandom_range(0, 99) < 3) begin
        rv.flush = 1'b1;
      end else begin
        rv.alloc_v = 1'($urandom_range(0, 1));
        rv.af      = 32'($urandom_range(0, 15)) * 32'h10;
        if ($urandom_range(0, 9) == 0 && rv.af >= 32'h10) rv.al = rv.af - 32'($urandom_range(1, 8));
        else rv.al = rv.af + 32'($urandom_range(0, 40));
        rv.free_v  = ($urandom_range(0, 4) == 0);
        rv.ff      = 32'($urandom_range(0, 15)) * 32'h10;
        rv.look_v  = 1'($urandom_range(0, 1));
        rv.la      = 32'($urandom_range(0, 300));
        rv.len     = 4'($urandom_range(0, 8));
        if ($urandom_range(0, 19) == 0) begin
          rv.af = 32'hFFFFFFF0;
          rv.al = 32'hFFFFFFFF;
          rv.la = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        end
      end
      modelStep(rv);
      applyStimulus(rv);
      checkOutput($sformatf("rand%0d", n), rv);
    end

    driveIdle();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
